// File: rtl/ll_v2_pkg.sv
// Shared types and sizes for the v2 linked-list engine.
// Pointer width follows the node-slot depth.
package ll_v2_pkg;

  localparam int DEPTH  = 16;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR_NODE,
    ST_WR_LINK,
    ST_RELEASE,
    ST_RESP
  } t_ll_wr_ctrl_state;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH_HEAD,
    OP_PUSH_TAIL,
    OP_POP_HEAD,
    OP_DEL_MID
  } t_ll_op;

endpackage

// File: rtl/ll_free_ptr_fifo.sv
// Circular FIFO of free node addresses, first-word fall-through.
// A push while full is dropped unless a pop frees a slot that cycle.
module ll_free_ptr_fifo
  import ll_v2_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [PTR_W-1:0] push_data,
  input  logic             pop,
  output logic [PTR_W-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count
);

  logic [PTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (PTR_W+1)'(DEPTH));
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_pop)  rd_ptr_d = inc(rd_ptr_q);
    if (do_push) wr_ptr_d = inc(wr_ptr_q);
    cnt_d = cnt_q + {{PTR_W{1'b0}}, do_push}
                  - {{PTR_W{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ll_wr_ctrl_v2.sv
// Write-side controller: allocates/releases node slots and
// issues dataMem/nxtptrMem writes for push, pop and delete ops.
module ll_wr_ctrl_v2
  import ll_v2_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  output logic              wr_ctrl_ready,
  input  logic              wr_ctrl_push_head,
  input  logic              wr_ctrl_push_tail,
  input  logic              wr_ctrl_pop_head,
  input  logic              wr_ctrl_del_mid,
  input  logic [DATA_W-1:0] wr_ctrl_data,
  input  logic [PTR_W-1:0]  wr_ctrl_head_ptr,
  input  logic [PTR_W-1:0]  wr_ctrl_link_ptr,
  input  logic [PTR_W-1:0]  wr_ctrl_victim_ptr,
  input  logic [PTR_W-1:0]  wr_ctrl_victim_nxt,
  input  logic [PTR_W:0]    wr_ctrl_ll_node_cnt,
  output logic              wr_ctrl_resp_vld,
  output logic [PTR_W-1:0]  wr_ctrl_new_head,
  output logic              wr_ctrl_err,
  output logic [PTR_W:0]    wr_ctrl_free_cnt,
  input  logic              ll_mngr_resp_taken,
  output logic              nxtptr_mem_wr_vld,
  output logic [PTR_W-1:0]  nxtptr_mem_wr_addr,
  output logic [PTR_W-1:0]  nxtptr_mem_wr_data,
  output logic              data_mem_wr_vld,
  output logic [PTR_W-1:0]  data_mem_wr_addr,
  output logic [DATA_W-1:0] data_mem_wr_data
);

  t_ll_wr_ctrl_state state_q, state_d;
  t_ll_op            op_q, op_d, op_sel;
  logic [DATA_W-1:0] data_q, data_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  link_q, link_d;
  logic [PTR_W-1:0]  victim_q, victim_d;
  logic [PTR_W-1:0]  vnxt_q, vnxt_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]  alloc_q, alloc_d;
  logic [PTR_W-1:0]  new_head_q, new_head_d;
  logic              err_q, err_d;
  logic [PTR_W-1:0]  init_cnt_q, init_cnt_d;

  logic              fifo_push, fifo_pop;
  logic [PTR_W-1:0]  fifo_push_data, fifo_pop_data;
  logic              fifo_empty, fifo_full;
  logic              op_is_push, op_err;

  ll_free_ptr_fifo u_free (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (wr_ctrl_free_cnt)
  );

  // Fixed priority when several op pulses coincide.
  always_comb begin
    op_sel = OP_NONE;
    if (wr_ctrl_del_mid)        op_sel = OP_DEL_MID;
    else if (wr_ctrl_pop_head)  op_sel = OP_POP_HEAD;
    else if (wr_ctrl_push_tail) op_sel = OP_PUSH_TAIL;
    else if (wr_ctrl_push_head) op_sel = OP_PUSH_HEAD;
  end

  assign op_is_push = (op_sel == OP_PUSH_HEAD)
                   || (op_sel == OP_PUSH_TAIL);

  always_comb begin
    op_err = 1'b0;
    if (op_is_push)
      op_err = fifo_empty;
    else if (op_sel == OP_POP_HEAD)
      op_err = (wr_ctrl_ll_node_cnt == '0);
    else if (op_sel == OP_DEL_MID)
      op_err = (wr_ctrl_ll_node_cnt < (PTR_W+1)'(2));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      op_q       <= OP_NONE;
      data_q     <= '0;
      head_q     <= '0;
      link_q     <= '0;
      victim_q   <= '0;
      vnxt_q     <= '0;
      cnt_q      <= '0;
      alloc_q    <= '0;
      new_head_q <= '0;
      err_q      <= 1'b0;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      head_q     <= head_d;
      link_q     <= link_d;
      victim_q   <= victim_d;
      vnxt_q     <= vnxt_d;
      cnt_q      <= cnt_d;
      alloc_q    <= alloc_d;
      new_head_q <= new_head_d;
      err_q      <= err_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    data_d         = data_q;
    head_d         = head_q;
    link_d         = link_q;
    victim_d       = victim_q;
    vnxt_d         = vnxt_q;
    cnt_d          = cnt_q;
    alloc_d        = alloc_q;
    new_head_d     = new_head_q;
    err_d          = err_q;
    init_cnt_d     = init_cnt_q;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    fifo_push_data = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        fifo_push  = 1'b1;
        init_cnt_d = init_cnt_q + PTR_W'(1);
        if (init_cnt_q == PTR_W'(DEPTH - 1))
          state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (op_sel != OP_NONE) begin
          op_d     = op_sel;
          data_d   = wr_ctrl_data;
          head_d   = wr_ctrl_head_ptr;
          link_d   = wr_ctrl_link_ptr;
          victim_d = wr_ctrl_victim_ptr;
          vnxt_d   = wr_ctrl_victim_nxt;
          cnt_d    = wr_ctrl_ll_node_cnt;
          err_d    = op_err;
          if (op_err) begin
            new_head_d = wr_ctrl_head_ptr;
            state_d    = ST_RESP;
          end else if (op_is_push) begin
            state_d = ST_WR_NODE;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_WR_NODE: begin
        fifo_pop = 1'b1;
        alloc_d  = fifo_pop_data;
        // Appending to a non-empty list still needs the old tail linked.
        if (op_q == OP_PUSH_TAIL && cnt_q != '0) begin
          new_head_d = head_q;
          state_d    = ST_WR_LINK;
        end else begin
          new_head_d = fifo_pop_data;
          state_d    = ST_RESP;
        end
      end
      ST_WR_LINK: state_d = ST_RESP;
      ST_RELEASE: begin
        fifo_push = 1'b1;
        if (op_q == OP_POP_HEAD) begin
          fifo_push_data = head_q;
          new_head_d     = vnxt_q;
        end else begin
          fifo_push_data = victim_q;
          new_head_d     = head_q;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (ll_mngr_resp_taken) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    wr_ctrl_ready      = 1'b0;
    wr_ctrl_resp_vld   = 1'b0;
    wr_ctrl_new_head   = '0;
    wr_ctrl_err        = 1'b0;
    nxtptr_mem_wr_vld  = 1'b0;
    nxtptr_mem_wr_addr = '0;
    nxtptr_mem_wr_data = '0;
    data_mem_wr_vld    = 1'b0;
    data_mem_wr_addr   = '0;
    data_mem_wr_data   = '0;
    // Held reset silences the strobes of an in-flight op.
    if (reset_n) begin
      wr_ctrl_new_head = new_head_q;
      wr_ctrl_err      = err_q;
      case (state_q)
        ST_IDLE: wr_ctrl_ready = 1'b1;
        ST_RESP: wr_ctrl_resp_vld = 1'b1;
        ST_WR_NODE: begin
          data_mem_wr_vld    = 1'b1;
          data_mem_wr_addr   = fifo_pop_data;
          data_mem_wr_data   = data_q;
          nxtptr_mem_wr_vld  = 1'b1;
          nxtptr_mem_wr_addr = fifo_pop_data;
          nxtptr_mem_wr_data =
            (op_q == OP_PUSH_HEAD) ? head_q : '0;
        end
        ST_WR_LINK: begin
          nxtptr_mem_wr_vld  = 1'b1;
          nxtptr_mem_wr_addr = link_q;
          nxtptr_mem_wr_data = alloc_q;
        end
        ST_RELEASE: begin
          if (op_q == OP_DEL_MID) begin
            nxtptr_mem_wr_vld  = 1'b1;
            nxtptr_mem_wr_addr = link_q;
            nxtptr_mem_wr_data = vnxt_q;
          end
        end
        default: ;
      endcase
    end
  end

  a_free_push_full: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(fifo_push && fifo_full && !fifo_pop)
  );

endmodule

// File: tb/tb_ll_wr_ctrl_v2.sv
// Bench for ll_wr_ctrl_v2: op table with a free-list model and
// write scoreboard, plus reset and re-init sequences.
module tb_ll_wr_ctrl_v2;
  import ll_v2_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ready;
  logic              push_head = 0, push_tail = 0;
  logic              pop_head = 0, del_mid = 0;
  logic [DATA_W-1:0] data = '0;
  logic [PTR_W-1:0]  head = '0, link = '0;
  logic [PTR_W-1:0]  victim = '0, vnxt = '0;
  logic [PTR_W:0]    node_cnt = '0;
  logic              resp_vld, err;
  logic [PTR_W-1:0]  new_head;
  logic [PTR_W:0]    free_cnt;
  logic              taken = 1'b0;
  logic              n_vld, d_vld;
  logic [PTR_W-1:0]  n_addr, n_data, d_addr;
  logic [DATA_W-1:0] d_data;

  always #5 clk = ~clk;

  ll_wr_ctrl_v2 dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .wr_ctrl_ready       (ready),
    .wr_ctrl_push_head   (push_head),
    .wr_ctrl_push_tail   (push_tail),
    .wr_ctrl_pop_head    (pop_head),
    .wr_ctrl_del_mid     (del_mid),
    .wr_ctrl_data        (data),
    .wr_ctrl_head_ptr    (head),
    .wr_ctrl_link_ptr    (link),
    .wr_ctrl_victim_ptr  (victim),
    .wr_ctrl_victim_nxt  (vnxt),
    .wr_ctrl_ll_node_cnt (node_cnt),
    .wr_ctrl_resp_vld    (resp_vld),
    .wr_ctrl_new_head    (new_head),
    .wr_ctrl_err         (err),
    .wr_ctrl_free_cnt    (free_cnt),
    .ll_mngr_resp_taken  (taken),
    .nxtptr_mem_wr_vld   (n_vld),
    .nxtptr_mem_wr_addr  (n_addr),
    .nxtptr_mem_wr_data  (n_data),
    .data_mem_wr_vld     (d_vld),
    .data_mem_wr_addr    (d_addr),
    .data_mem_wr_data    (d_data)
  );

  typedef struct {
    logic [3:0]        ops;  // {del, pop, tail, head}
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0]  head, link, vic, vnxt;
    logic [PTR_W:0]    cnt;
    logic [PTR_W-1:0]  exp_head;
    logic              exp_err;
    int                exp_lat;
  } vec_t;

  typedef struct {
    logic [PTR_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  vec_t             vt[26];
  wr_t              exp_d_q[$];
  wr_t              exp_n_q[$];
  logic [PTR_W-1:0] free_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  bit               mon_en = 0;
  bit               watch_en = 0;
  int               link_hits = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [3:0] ops, input logic [DATA_W-1:0] d,
    input logic [PTR_W-1:0] h, input logic [PTR_W-1:0] l,
    input logic [PTR_W-1:0] vi, input logic [PTR_W-1:0] vn,
    input logic [PTR_W:0] c, input logic [PTR_W-1:0] eh,
    input logic ee, input int el);
    vec_t v;
    v.ops = ops; v.data = d; v.head = h; v.link = l;
    v.vic = vi; v.vnxt = vn; v.cnt = c;
    v.exp_head = eh; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (mon_en && d_vld) begin
      if (exp_d_q.size() == 0) chk("data_wr_unexpected", 1, 0);
      else begin
        e = exp_d_q.pop_front();
        chk("data_wr_addr", d_addr, e.addr);
        chk("data_wr_data", d_data, e.data);
      end
    end
    if (mon_en && n_vld) begin
      if (exp_n_q.size() == 0) chk("nxt_wr_unexpected", 1, 0);
      else begin
        e = exp_n_q.pop_front();
        chk("nxt_wr_addr", n_addr, e.addr);
        chk("nxt_wr_data", n_data, e.data);
      end
    end
    if (watch_en && n_vld && n_addr == 4'd5) link_hits++;
  end

  task automatic model(input vec_t v);
    logic [PTR_W-1:0] a;
    if (v.ops[3]) begin
      if (v.cnt >= 2) begin
        exp_n_q.push_back('{v.link, DATA_W'(v.vnxt)});
        free_q.push_back(v.vic);
      end
    end else if (v.ops[2]) begin
      if (v.cnt != 0) free_q.push_back(v.head);
    end else if (free_q.size() != 0) begin
      a = free_q.pop_front();
      exp_d_q.push_back('{a, v.data});
      exp_n_q.push_back('{a, v.ops[1] ? '0 : DATA_W'(v.head)});
      if (v.ops[1] && v.cnt != 0)
        exp_n_q.push_back('{v.link, DATA_W'(a)});
    end
  endtask

  task automatic drive(input vec_t v);
    push_head = v.ops[0]; push_tail = v.ops[1];
    pop_head = v.ops[2]; del_mid = v.ops[3];
    data = v.data; head = v.head; link = v.link;
    victim = v.vic; vnxt = v.vnxt; node_cnt = v.cnt;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    lat = 0;
    while (!ready && lat < 40) begin
      @(negedge clk); lat++;
    end
    chk($sformatf("ready_v%0d", idx), ready, 1);
    model(v);
    #1 drive(v);
    @(posedge clk);
    #1 {push_head, push_tail, pop_head, del_mid} = '0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!resp_vld && lat < 8);
    chk($sformatf("resp_vld_v%0d", idx), resp_vld, 1);
    chk($sformatf("latency_v%0d", idx), lat, v.exp_lat);
    chk($sformatf("new_head_v%0d", idx), new_head, v.exp_head);
    chk($sformatf("err_v%0d", idx), err, v.exp_err);
    @(negedge clk);
    chk($sformatf("resp_held_v%0d", idx),
        {resp_vld, new_head, err}, {1'b1, v.exp_head, v.exp_err});
    #1 taken = 1'b1;
    @(posedge clk);
    #1 taken = 1'b0;
    @(negedge clk);
    chk($sformatf("idle_v%0d", idx), {ready, resp_vld}, 2'b10);
    chk($sformatf("free_cnt_v%0d", idx), free_cnt, free_q.size());
    chk($sformatf("wr_left_v%0d", idx),
        exp_d_q.size() + exp_n_q.size(), 0);
  endtask

  task automatic do_reset();
    int first;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs",
        {ready, resp_vld, err, new_head, free_cnt, n_vld, d_vld}, 0);
    #1 reset_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (ready) begin first = i; break; end
    end
    chk("first_ready_cycle", first, 16);
    chk("init_free_cnt", free_cnt, 16);
    chk("init_resp_vld", resp_vld, 0);
    free_q.delete();
    exp_d_q.delete();
    exp_n_q.delete();
    for (int i = 0; i < DEPTH; i++) free_q.push_back(PTR_W'(i));
  endtask

  initial begin
    vt[0] = mk(4'b0001, 'hA5, 0, 0, 0, 0, 0, 0, 0, 2);
    vt[1] = mk(4'b0010, 'h11, 0, 0, 0, 0, 1, 0, 0, 3);
    vt[2] = mk(4'b0010, 'h22, 0, 1, 0, 0, 2, 0, 0, 3);
    vt[3] = mk(4'b1000, 'h0, 0, 0, 1, 2, 3, 0, 0, 2);
    vt[4] = mk(4'b0100, 'h0, 5, 0, 0, 0, 0, 5, 1, 1);
    vt[5] = mk(4'b1000, 'h0, 7, 0, 0, 0, 1, 7, 1, 1);
    vt[6] = mk(4'b1111, 'h77, 9, 0, 0, 0, 1, 9, 1, 1);
    vt[7] = mk(4'b0111, 'h78, 0, 0, 0, 2, 2, 2, 0, 2);
    vt[8] = mk(4'b0001, 'h33, 2, 0, 0, 0, 1, 3, 0, 2);
    vt[9] = mk(4'b0011, 'h44, 6, 0, 0, 0, 0, 4, 0, 2);
    // Drain: slots 5..15, then released 1 and 0 wrap around.
    for (int i = 0; i < 13; i++)
      vt[10+i] = mk(4'b0001, 'h100 + i, 4'(i), 0, 0, 0, 2,
                    (i < 11) ? 4'(5 + i) : (i == 11 ? 4'd1 : 4'd0),
                    0, 2);
    vt[23] = mk(4'b0001, 'hDEAD, 'hC, 0, 0, 0, 5, 'hC, 1, 1);
    vt[24] = mk(4'b0100, 'h0, 0, 0, 0, 1, 5, 1, 0, 2);
    vt[25] = mk(4'b0001, 'h5A, 3, 0, 0, 0, 0, 0, 0, 2);

    do_reset();
    mon_en = 1;
    for (int i = 0; i < 25; i++) run_vec(i, vt[i]);
    chk("free_cnt_after_pop", free_cnt, 1);

    // Reset while push_tail sits in WR_NODE.
    mon_en = 0;
    watch_en = 1;
    @(negedge clk);
    #1 drive(mk(4'b0010, 'hBB, 0, 5, 0, 0, 3, 0, 0, 3));
    @(posedge clk);
    #1 {push_head, push_tail, pop_head, del_mid} = '0;
    reset_n = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    watch_en = 0;
    chk("no_link_wr_after_rst", link_hits, 0);
    chk("rst_free_cnt", free_cnt, 16);
    chk("rst_resp_vld", resp_vld, 0);

    mon_en = 1;
    run_vec(25, vt[25]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
